// File: rtl/seri2para_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seri2para_pkg
//  Description : Shared types and default sizing for the serial-to-parallel
//                pixel word assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
package seri2para_pkg;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Default geometry: 40 words of 16 bits covers one 640-pixel line
    localparam int DEF_WORD_W    = 16;
    localparam int DEF_NUM_WORDS = 40;

endpackage : seri2para_pkg
`default_nettype wire

// File: rtl/seri2para.sv
`default_nettype none
// ============================================================================
//  Module      : seri2para
//  Description : Collects a serial pixel stream (MSB first) into WORD_W-bit
//                words, presents them through a valid/ready output register
//                and counts NUM_WORDS words per transfer. Words completing
//                while the previous one is still pending are dropped and
//                flagged on a sticky overrun output.
//                Optional build macro SERI2PARA_OVERRUN_CNT_EN adds an 8-bit
//                saturating dropped-word counter on port oOverrunCnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module seri2para
    import seri2para_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              iPIXEL,
    input  logic              iVALID,
    output logic [WORD_W-1:0] oWORD,
    output logic              oWORD_VALID,
    input  logic              iWORD_READY,
    output logic              oFinished,
    output logic              oBusy,
`ifdef SERI2PARA_OVERRUN_CNT_EN
    output logic [7:0]        oOverrunCnt,
`endif
    output logic              oOverrun
);

    localparam int c_BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int c_WCNT_W = $clog2(NUM_WORDS + 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(WORD_W - 1);
    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(NUM_WORDS - 1);

    state_e              state_q,    state_d;
    logic [c_BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [c_WCNT_W-1:0] word_cnt_q, word_cnt_d;
    // The bit that completes a word is taken straight from iPIXEL, so the
    // shift register only ever needs to hold WORD_W-1 earlier bits.
    logic [WORD_W-2:0]   shreg_q,    shreg_d;
    logic [WORD_W-1:0]   word_q,     word_d;
    logic                wvalid_q,   wvalid_d;
    logic                ovr_q,      ovr_d;
`ifdef SERI2PARA_OVERRUN_CNT_EN
    logic [7:0]          ovr_cnt_q,  ovr_cnt_d;
`endif

    logic [WORD_W-1:0]   w_next_word;
    logic                w_accept;

    assign w_next_word = {shreg_q, iPIXEL};
    assign w_accept    = wvalid_q & iWORD_READY;

    // Next-state, counter, datapath and handshake decode
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        wvalid_d   = wvalid_q;
        ovr_d      = ovr_q;
`ifdef SERI2PARA_OVERRUN_CNT_EN
        ovr_cnt_d  = ovr_cnt_q;
`endif

        // A consumed word frees the output register; a load below overrides
        if (w_accept) begin
            wvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    shreg_d    = '0;
                    ovr_d      = 1'b0;
`ifdef SERI2PARA_OVERRUN_CNT_EN
                    ovr_cnt_d  = '0;
`endif
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iVALID) begin
                    shreg_d = w_next_word[WORD_W-2:0];
                    if (bit_cnt_q == c_LAST_BIT) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (!wvalid_q || iWORD_READY) begin
                            word_d   = w_next_word;
                            wvalid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
`ifdef SERI2PARA_OVERRUN_CNT_EN
                            if (ovr_cnt_q != 8'hFF) begin
                                ovr_cnt_d = ovr_cnt_q + 8'd1;
                            end
`endif
                        end
                        if (word_cnt_q == c_LAST_WORD) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!wvalid_q || iWORD_READY) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            wvalid_q   <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef SERI2PARA_OVERRUN_CNT_EN
            ovr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            wvalid_q   <= wvalid_d;
            ovr_q      <= ovr_d;
`ifdef SERI2PARA_OVERRUN_CNT_EN
            ovr_cnt_q  <= ovr_cnt_d;
`endif
        end
    end

    assign oWORD       = word_q;
    assign oWORD_VALID = wvalid_q;
    assign oOverrun    = ovr_q;
    assign oFinished   = (state_q == ST_DONE);
    assign oBusy       = (state_q != ST_IDLE);
`ifdef SERI2PARA_OVERRUN_CNT_EN
    assign oOverrunCnt = ovr_cnt_q;
`endif

endmodule : seri2para
`default_nettype wire

// File: tb/tb_seri2para.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seri2para
//  Description : Directed self-checking bench for seri2para with
//                WORD_W=16, NUM_WORDS=2 (two words per transfer).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seri2para;

    localparam int c_WORD_W    = 16;
    localparam int c_NUM_WORDS = 2;
    localparam logic [15:0] c_W0 = 16'hA5C3;
    localparam logic [15:0] c_W1 = 16'h0F0F;

    logic                iCLK = 1'b0;
    logic                iRST_n;
    logic                iSTART;
    logic                iPIXEL;
    logic                iVALID;
    logic [c_WORD_W-1:0] oWORD;
    logic                oWORD_VALID;
    logic                iWORD_READY;
    logic                oFinished;
    logic                oBusy;
    logic                oOverrun;
`ifdef SERI2PARA_OVERRUN_CNT_EN
    logic [7:0]          oOverrunCnt;
`endif

    int checks   = 0;
    int failures = 0;
    int fin_cnt  = 0;
    int fin0;
    logic [15:0] acc_q[$];

    seri2para #(
        .WORD_W    (c_WORD_W),
        .NUM_WORDS (c_NUM_WORDS)
    ) u_dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iSTART      (iSTART),
        .iPIXEL      (iPIXEL),
        .iVALID      (iVALID),
        .oWORD       (oWORD),
        .oWORD_VALID (oWORD_VALID),
        .iWORD_READY (iWORD_READY),
        .oFinished   (oFinished),
        .oBusy       (oBusy),
`ifdef SERI2PARA_OVERRUN_CNT_EN
        .oOverrunCnt (oOverrunCnt),
`endif
        .oOverrun    (oOverrun)
    );

    always #5 iCLK = ~iCLK;

    // Record finish pulses and every accepted word, mid-cycle
    always @(negedge iCLK) begin
        if (iRST_n === 1'b1) begin
            if (oFinished === 1'b1) fin_cnt++;
            if (oWORD_VALID === 1'b1 && iWORD_READY === 1'b1) acc_q.push_back(oWORD);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        tick();
        tick();
        iRST_n = 1'b1;
    endtask

    task automatic do_start();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
    endtask

    // Send the top nbits of w MSB first; optional idle gap before each bit,
    // optional ready raise on the final bit, optional iSTART pulse mid-word
    task automatic send_word(input logic [15:0] w, input int nbits, input bit gap,
                             input bit rdy_last, input bit start_mid);
        for (int i = 15; i >= 16 - nbits; i--) begin
            if (gap) begin
                iVALID = 1'b0;
                tick();
            end
            if (rdy_last && i == 0) iWORD_READY = 1'b1;
            iSTART = start_mid && (i == 8);
            iVALID = 1'b1;
            iPIXEL = w[i];
            tick();
        end
        iVALID = 1'b0;
        iSTART = 1'b0;
    endtask

    // Nominal transfer, consumer always ready
    task automatic run_basic(input string tag, input bit gap, input bit start_mid);
        iWORD_READY = 1'b1;
        fin0 = fin_cnt;
        acc_q.delete();
        do_start();
        check({tag, "_busy"}, 32'(oBusy), 32'd1);
        send_word(c_W0, 16, gap, 1'b0, start_mid);
        check({tag, "_w0_valid"}, 32'(oWORD_VALID), 32'd1);
        check({tag, "_w0"}, 32'(oWORD), 32'(c_W0));
        send_word(c_W1, 16, gap, 1'b0, start_mid);
        check({tag, "_w1_valid"}, 32'(oWORD_VALID), 32'd1);
        check({tag, "_w1"}, 32'(oWORD), 32'(c_W1));
        tick();
        check({tag, "_fin"}, 32'(oFinished), 32'd1);
        tick();
        check({tag, "_fin_end"}, 32'(oFinished), 32'd0);
        check({tag, "_idle"}, 32'(oBusy), 32'd0);
        check({tag, "_ovr"}, 32'(oOverrun), 32'd0);
        check({tag, "_fin_cnt"}, 32'(fin_cnt - fin0), 32'd1);
        check({tag, "_acc_n"}, 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            check({tag, "_acc0"}, 32'(acc_q[0]), 32'(c_W0));
            check({tag, "_acc1"}, 32'(acc_q[1]), 32'(c_W1));
        end
    endtask

    initial begin
        iRST_n      = 1'b0;
        iSTART      = 1'b0;
        iPIXEL      = 1'b0;
        iVALID      = 1'b0;
        iWORD_READY = 1'b0;
        do_reset();

        // Reset state
        check("rst_word",  32'(oWORD), 32'd0);
        check("rst_valid", 32'(oWORD_VALID), 32'd0);
        check("rst_fin",   32'(oFinished), 32'd0);
        check("rst_busy",  32'(oBusy), 32'd0);
        check("rst_ovr",   32'(oOverrun), 32'd0);

        // Contiguous bits, then every-other-cycle valid
        run_basic("contig", 1'b0, 1'b0);
        run_basic("gapped", 1'b1, 1'b0);

        // Consumer stalled through both words
        iWORD_READY = 1'b0;
        fin0 = fin_cnt;
        acc_q.delete();
        do_start();
        send_word(c_W0, 16, 1'b0, 1'b0, 1'b0);
        check("stall_w0", 32'(oWORD), 32'(c_W0));
        send_word(c_W1, 16, 1'b0, 1'b0, 1'b0);
        check("stall_ovr",   32'(oOverrun), 32'd1);
        check("stall_hold",  32'(oWORD), 32'(c_W0));
        check("stall_valid", 32'(oWORD_VALID), 32'd1);
        for (int k = 0; k < 3; k++) tick();
        check("stall_drain_busy", 32'(oBusy), 32'd1);
        check("stall_no_fin", 32'(fin_cnt - fin0), 32'd0);
        iWORD_READY = 1'b1;
        tick();
        check("stall_fin",    32'(oFinished), 32'd1);
        check("stall_vclr",   32'(oWORD_VALID), 32'd0);
        tick();
        check("stall_idle",   32'(oBusy), 32'd0);
        check("stall_sticky", 32'(oOverrun), 32'd1);
        check("stall_acc_n",  32'(acc_q.size()), 32'd1);

        // Ready rises exactly as the second word completes
        iWORD_READY = 1'b0;
        fin0 = fin_cnt;
        acc_q.delete();
        do_start();
        check("edge_ovr_clr", 32'(oOverrun), 32'd0);
        send_word(c_W0, 16, 1'b0, 1'b0, 1'b0);
        send_word(c_W1, 16, 1'b0, 1'b1, 1'b0);
        check("edge_ovr",   32'(oOverrun), 32'd0);
        check("edge_valid", 32'(oWORD_VALID), 32'd1);
        check("edge_w1",    32'(oWORD), 32'(c_W1));
        tick();
        check("edge_fin",   32'(oFinished), 32'd1);
        tick();
        check("edge_acc_n", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            check("edge_acc0", 32'(acc_q[0]), 32'(c_W0));
            check("edge_acc1", 32'(acc_q[1]), 32'(c_W1));
        end

        // Reset in the middle of a word
        iWORD_READY = 1'b1;
        do_start();
        send_word(c_W0, 10, 1'b0, 1'b0, 1'b0);
        fin0 = fin_cnt;
        iRST_n = 1'b0;
        tick();
        check("mrst_word",  32'(oWORD), 32'd0);
        check("mrst_valid", 32'(oWORD_VALID), 32'd0);
        check("mrst_fin",   32'(oFinished), 32'd0);
        check("mrst_busy",  32'(oBusy), 32'd0);
        check("mrst_ovr",   32'(oOverrun), 32'd0);
        iRST_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("mrst_no_fin", 32'(fin_cnt - fin0), 32'd0);
        run_basic("after_rst", 1'b0, 1'b0);

        // iVALID pulsed while idle, then iSTART pulsed while running
        iVALID = 1'b1;
        iPIXEL = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        iVALID = 1'b0;
        check("idle_busy",  32'(oBusy), 32'd0);
        check("idle_valid", 32'(oWORD_VALID), 32'd0);
        run_basic("start_mid", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_seri2para
`default_nettype wire
